uart_tx_ctrl: RTL and testbench

Memory-mapped UART transmit controller on the core's data-memory port at UART base 0x0050_0000. It accepts byte stores from the load/store path into a TX FIFO and sequences the 8N1 serial shifter with a programmable baud divider. It stalls the store path when the FIFO is full, so back-to-back `sb` streams such as "Hello World!\n\r" are never dropped.

---
 rtl/uart_tx_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter: byte stores fill a TX FIFO that a
// baud-timed shifter drains back-to-back. Full FIFO stalls TXDATA stores.
module uart_tx_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h0050_0000,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [15:0] CLK_DIV_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_data_wr_en,
  input  logic        mem_data_rd_en,
  output logic [31:0] mem_read_data,
  output logic        mem_stall,
  output logic        uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   baud_div, active_div, baud_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [31:0]   status;

  logic       hit, tx_wr, full, empty, push, pop, bit_end, busy;
  logic [1:0] sel;

  assign hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign sel     = mem_addr[3:2];
  assign tx_wr   = hit && mem_data_wr_en && (sel == 2'd0);
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push    = tx_wr && !full;
  assign mem_stall = tx_wr && full;
  assign bit_end = (baud_cnt == active_div - 16'd1);
  assign busy    = (state != IDLE);
  // A pop only happens when the shifter is ready for the next frame.
  assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));

  always_comb begin
    status          = '0;
    status[0]       = busy;
    status[1]       = full;
    status[2]       = empty;
    status[4+AW:4]  = count;
    mem_read_data   = '0;
    if (hit && mem_data_rd_en) begin
      case (sel)
        2'd1:    mem_read_data = status;
        2'd2:    mem_read_data = {16'h0, baud_div};
        default: mem_read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_write_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_div <= CLK_DIV_DEFAULT;
    end else if (hit && mem_data_wr_en && sel == 2'd2) begin
      baud_div <= (mem_write_data[15:0] == 16'd0) ? 16'd1 : mem_write_data[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      active_div <= CLK_DIV_DEFAULT;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      uart_tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg      <= fifo_mem[rd_ptr];
            active_div <= baud_div;
            baud_cnt   <= '0;
            uart_tx    <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // Queued data chains straight into the next start bit.
            if (pop) begin
              shreg      <= fifo_mem[rd_ptr];
              active_div <= baud_div;
              uart_tx    <= 1'b0;
              state      <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: register vector table, scoreboarded serial frame
// monitor, and directed sequences for stall, baud change and mid-frame reset.
module tb_uart_tx_ctrl;
  localparam logic [31:0] BASE = 32'h0050_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_data_wr_en, mem_data_rd_en, mem_stall, uart_tx;

  uart_tx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_data_wr_en(mem_data_wr_en), .mem_data_rd_en(mem_data_rd_en),
    .mem_read_data(mem_read_data), .mem_stall(mem_stall), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb [$];
  int m_baud = 434;
  int cyc = 0;
  int frames_started = 0;
  bit in_frame = 0;
  bit chk_gap = 0;
  bit have_prev = 0;
  int prev_start, prev_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Frame monitor: checks every sample of each frame against the scoreboard byte.
  int         m_d, m_b;
  logic [7:0] m_e, m_got;
  logic       m_lvl;
  bit         m_bad, m_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx == 1'b0) begin
        m_d = m_baud;
        frames_started++;
        in_frame = 1;
        m_bad = 0; m_abort = 0; m_got = 8'h0;
        if (chk_gap && have_prev) chk("frame_gap", 32'(cyc - prev_start), 32'(10 * prev_d));
        if (chk_gap) begin have_prev = 1; prev_start = cyc; prev_d = m_d; end
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_frame: start bit at cycle %0d with empty scoreboard", cyc);
          m_e = 8'h0;
        end else begin
          m_e = sb.pop_front();
        end
        for (int c = 1; c < 10 * m_d; c++) begin
          @(negedge clk);
          if (!rst_n) begin m_abort = 1; break; end
          m_b = c / m_d;
          m_lvl = (m_b == 0) ? 1'b0 : (m_b == 9) ? 1'b1 : m_e[m_b-1];
          if (uart_tx !== m_lvl) m_bad = 1;
          if (m_b >= 1 && m_b <= 8 && (c % m_d) == m_d / 2) m_got[m_b-1] = uart_tx;
        end
        if (!m_abort) begin
          chk("frame_byte", 32'(m_got), 32'(m_e));
          chk("frame_shape_err", 32'(m_bad), 32'h0);
        end
        in_frame = 0;
      end
    end
  end

  task automatic acc(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic wr, input logic rd, input logic [31:0] exp_rd, input logic exp_stall);
    mem_addr = addr; mem_write_data = wdata; mem_data_wr_en = wr; mem_data_rd_en = rd;
    #1;
    chk({name, "_rdata"}, mem_read_data, exp_rd);
    chk({name, "_stall"}, 32'(mem_stall), 32'(exp_stall));
    @(posedge clk); #1;
    mem_data_wr_en = 1'b0; mem_data_rd_en = 1'b0;
  endtask

  task automatic sb_write(input logic [7:0] b, output int stalls);
    mem_addr = BASE; mem_write_data = {24'h0, b}; mem_data_wr_en = 1'b1; mem_data_rd_en = 1'b0;
    stalls = 0;
    forever begin
      #1;
      if (!mem_stall) break;
      stalls++;
      if (stalls >= 2000) begin
        chk("stall_timeout", 32'(stalls), 32'h0);
        break;
      end
      @(posedge clk); #1;
    end
    sb.push_back(b);
    @(posedge clk); #1;
    mem_data_wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || in_frame) && n < budget) begin
      @(posedge clk); n++;
    end
    chk("drain_pending", 32'(sb.size()) + 32'(in_frame), 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_started < target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk("wait_frames", 32'(frames_started >= target), 32'h1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] exp_rd;
    logic        exp_stall;
  } vec_t;

  vec_t tbl [13];
  int   st, f0;
  logic [7:0] msg [18];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{BASE + 32'h4,  32'h0,     1'b0, 1'b1, 32'h4,      1'b0}; // idle, empty
    tbl[1]  = '{BASE + 32'h8,  32'h0,     1'b0, 1'b1, 32'h1B2,    1'b0}; // default 434
    tbl[2]  = '{BASE + 32'h8,  32'h0,     1'b1, 1'b0, 32'h0,      1'b0}; // write 0
    tbl[3]  = '{BASE + 32'h8,  32'h0,     1'b0, 1'b1, 32'h1,      1'b0}; // stored as 1
    tbl[4]  = '{BASE + 32'h8,  32'hAB0004,1'b1, 1'b0, 32'h0,      1'b0}; // only [15:0] kept
    tbl[5]  = '{BASE + 32'h8,  32'h0,     1'b0, 1'b1, 32'h4,      1'b0};
    tbl[6]  = '{BASE,          32'h0,     1'b0, 1'b1, 32'h0,      1'b0}; // TXDATA reads 0
    tbl[7]  = '{BASE + 32'hC,  32'h0,     1'b0, 1'b1, 32'h0,      1'b0}; // reserved
    tbl[8]  = '{BASE + 32'h10, 32'h55,    1'b1, 1'b0, 32'h0,      1'b0}; // non-hit write
    tbl[9]  = '{BASE + 32'h10, 32'h0,     1'b0, 1'b1, 32'h0,      1'b0}; // non-hit read
    tbl[10] = '{BASE + 32'hC,  32'hFF,    1'b1, 1'b0, 32'h0,      1'b0}; // reserved write
    tbl[11] = '{BASE + 32'h4,  32'h0,     1'b0, 1'b1, 32'h4,      1'b0}; // still nothing pushed
    tbl[12] = '{BASE + 32'h8,  32'h0,     1'b0, 1'b0, 32'h0,      1'b0}; // no rd strobe
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72,
            8'h6C, 8'h64, 8'h21, 8'h0A, 8'h0D, 8'h48, 8'h65, 8'h6C, 8'h6C};

    rst_n = 1'b0; mem_addr = '0; mem_write_data = '0; mem_data_wr_en = 1'b0; mem_data_rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uart_tx", 32'(uart_tx), 32'h1);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_rdata", mem_read_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      acc($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].wr, tbl[i].rd,
          tbl[i].exp_rd, tbl[i].exp_stall);
    m_baud = 4;

    // Single 'H' frame: start bit visible one edge after the accepting edge.
    sb_write(8'h48, st);
    chk("lat_edge_k", 32'(uart_tx), 32'h1);
    @(posedge clk); #1;
    chk("lat_edge_k1", 32'(uart_tx), 32'h0);
    acc("status_busy", BASE + 32'h4, 32'h0, 1'b0, 1'b1, 32'h5, 1'b0);
    drain(200);
    acc("status_idle", BASE + 32'h4, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);

    // Back-to-back stream: 17 writes fill the FIFO (first byte already popped).
    chk_gap = 1; have_prev = 0;
    for (int i = 0; i < 17; i++) sb_write(msg[i], st);
    acc("status_full", BASE + 32'h4, 32'h0, 1'b0, 1'b1, 32'h103, 1'b0);
    // First frame popped at edge 2 ends at edge 42; 18th write waits edges 19..42.
    sb_write(msg[17], st);
    chk("stall_cycles", 32'(st), 32'd24);
    drain(2000);
    chk_gap = 0;

    // Mid-frame divider change applies to the following frame only.
    f0 = frames_started;
    sb_write(8'h41, st);
    sb_write(8'h42, st);
    wait_frames(f0 + 1, 100);
    repeat (10) @(posedge clk);
    #1;
    acc("baud_mid", BASE + 32'h8, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0);
    m_baud = 8;
    drain(400);
    acc("baud_rb8", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 32'h8, 1'b0);
    acc("baud_set4", BASE + 32'h8, 32'h4, 1'b1, 1'b0, 32'h0, 1'b0);
    m_baud = 4;

    // Reset in DATA bit 3 of the first frame with five more bytes queued.
    f0 = frames_started;
    for (int i = 0; i < 6; i++) sb_write(8'hC3 + 8'(i), st);
    wait_frames(f0 + 1, 100);
    repeat (17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_uart_tx", 32'(uart_tx), 32'h1);
    chk("rst_mid_stall", 32'(mem_stall), 32'h0);
    sb.delete();
    m_baud = 434;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc("rst_status", BASE + 32'h4, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
    acc("rst_baud", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 32'h1B2, 1'b0);
    f0 = frames_started;
    repeat (200) @(posedge clk);
    #1;
    chk("no_resume_frames", 32'(frames_started), 32'(f0));
    chk("no_resume_line", 32'(uart_tx), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
